// File: rtl/video_bouncing_box.sv
// video_bouncing_box
// Draws a solid square that bounces around the visible area. The box moves
// once per frame (on the rising edge of vblank) and changes colour every time
// it hits an edge. The generator's timing is delayed by two cycles so that the
// sync and visible outputs line up with the colour.
//
// Ports
//   i_clk, i_rst_n         pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync       sync from the timing generator
//   i_hblank, i_vblank     blanking flags (vblank rising edge is the frame tick)
//   i_visible              active-video flag
//   i_hpos, i_vpos         current pixel coordinates
//   o_hsync, o_vsync       sync delayed by two cycles, polarity unchanged
//   o_visible              i_visible delayed by two cycles
//   o_red, o_grn, o_blu    pixel colour, 3 bits per channel
module video_bouncing_box #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BOX_SIZE  = 16,
  parameter int H_SPEED   = 2,
  parameter int V_SPEED   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_hblank,
  input  logic       i_vblank,
  input  logic       i_visible,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_visible,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu
);

  localparam logic [10:0] MAX_X = 11'(H_VISIBLE - BOX_SIZE);
  localparam logic [10:0] MAX_Y = 11'(V_VISIBLE - BOX_SIZE);
  localparam logic [10:0] H_SPD = 11'(H_SPEED);
  localparam logic [10:0] V_SPD = 11'(V_SPEED);
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);

  // hblank carries no information the box needs; visible already covers it.
  logic unused_hblank;
  assign unused_hblank = i_hblank;

  logic [9:0] box_x, box_y;
  logic       dir_x, dir_y;
  logic [2:0] col;
  logic       prev_vblank;
  logic       tick;

  logic [9:0] x_nxt, y_nxt;
  logic       dx_nxt, dy_nxt;
  logic       x_hit, y_hit;

  assign tick = i_vblank & ~prev_vblank;

  // Horizontal step: clamp at either end and reverse direction.
  always_comb begin
    x_nxt  = box_x;
    dx_nxt = dir_x;
    x_hit  = 1'b0;
    if (dir_x) begin
      if ({1'b0, box_x} + H_SPD >= MAX_X) begin
        x_nxt  = MAX_X[9:0];
        dx_nxt = 1'b0;
        x_hit  = 1'b1;
      end else begin
        x_nxt = box_x + H_SPD[9:0];
      end
    end else begin
      if ({1'b0, box_x} <= H_SPD) begin
        x_nxt  = '0;
        dx_nxt = 1'b1;
        x_hit  = 1'b1;
      end else begin
        x_nxt = box_x - H_SPD[9:0];
      end
    end
  end

  // Vertical step, same rule as horizontal.
  always_comb begin
    y_nxt  = box_y;
    dy_nxt = dir_y;
    y_hit  = 1'b0;
    if (dir_y) begin
      if ({1'b0, box_y} + V_SPD >= MAX_Y) begin
        y_nxt  = MAX_Y[9:0];
        dy_nxt = 1'b0;
        y_hit  = 1'b1;
      end else begin
        y_nxt = box_y + V_SPD[9:0];
      end
    end else begin
      if ({1'b0, box_y} <= V_SPD) begin
        y_nxt  = '0;
        dy_nxt = 1'b1;
        y_hit  = 1'b1;
      end else begin
        y_nxt = box_y - V_SPD[9:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_vblank <= 1'b0;
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      col         <= 3'd7;
    end else begin
      prev_vblank <= i_vblank;
      if (tick) begin
        box_x <= x_nxt;
        box_y <= y_nxt;
        dir_x <= dx_nxt;
        dir_y <= dy_nxt;
        // A corner hit is still a single bounce; colour skips 0.
        if (x_hit || y_hit) col <= (col == 3'd7) ? 3'd1 : col + 3'd1;
      end
    end
  end

  logic       in_box;
  logic [8:0] box_rgb;

  always_comb begin
    in_box = i_visible
           && ({1'b0, i_hpos} >= {1'b0, box_x}) && ({1'b0, i_hpos} < {1'b0, box_x} + BOX)
           && ({1'b0, i_vpos} >= {1'b0, box_y}) && ({1'b0, i_vpos} < {1'b0, box_y} + BOX);
    box_rgb = in_box ? {{3{col[2]}}, {3{col[1]}}, {3{col[0]}}} : '0;
  end

  // Colour is resolved in the first stage so the box state it used travels
  // with the pixel; the second stage only delays.
  logic       s1_hsync, s1_vsync, s1_visible;
  logic [8:0] s1_rgb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_visible <= 1'b0;
      s1_rgb     <= '0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      o_visible  <= 1'b0;
      o_red      <= '0;
      o_grn      <= '0;
      o_blu      <= '0;
    end else begin
      s1_hsync   <= i_hsync;
      s1_vsync   <= i_vsync;
      s1_visible <= i_visible;
      s1_rgb     <= box_rgb;
      o_hsync    <= s1_hsync;
      o_vsync    <= s1_vsync;
      o_visible  <= s1_visible;
      o_red      <= s1_rgb[8:6];
      o_grn      <= s1_rgb[5:3];
      o_blu      <= s1_rgb[2:0];
    end
  end

endmodule

// File: tb/tb_video_bouncing_box.sv
module tb_video_bouncing_box;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs, vs, hb, vb, vis;
  logic [9:0] hp, vp;

  logic       o_hs [3];
  logic       o_vs [3];
  logic       o_vis[3];
  logic [2:0] o_r  [3];
  logic [2:0] o_g  [3];
  logic [2:0] o_b  [3];

  always #5 clk = ~clk;

  video_bouncing_box dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_hblank(hb),
    .i_vblank(vb), .i_visible(vis), .i_hpos(hp), .i_vpos(vp),
    .o_hsync(o_hs[0]), .o_vsync(o_vs[0]), .o_visible(o_vis[0]),
    .o_red(o_r[0]), .o_grn(o_g[0]), .o_blu(o_b[0]));

  video_bouncing_box #(.H_VISIBLE(10), .V_VISIBLE(6), .BOX_SIZE(2), .H_SPEED(3), .V_SPEED(1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_hblank(hb),
    .i_vblank(vb), .i_visible(vis), .i_hpos(hp), .i_vpos(vp),
    .o_hsync(o_hs[1]), .o_vsync(o_vs[1]), .o_visible(o_vis[1]),
    .o_red(o_r[1]), .o_grn(o_g[1]), .o_blu(o_b[1]));

  video_bouncing_box #(.H_VISIBLE(6), .V_VISIBLE(6), .BOX_SIZE(2), .H_SPEED(1), .V_SPEED(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_hblank(hb),
    .i_vblank(vb), .i_visible(vis), .i_hpos(hp), .i_vpos(vp),
    .o_hsync(o_hs[2]), .o_vsync(o_vs[2]), .o_visible(o_vis[2]),
    .o_red(o_r[2]), .o_grn(o_g[2]), .o_blu(o_b[2]));

  // Reference model: per-instance parameters and box state as plain integers.
  int HV[3] = '{640, 10, 6};
  int VV[3] = '{480, 6, 6};
  int BS[3] = '{16, 2, 2};
  int HS[3] = '{2, 3, 1};
  int VS[3] = '{1, 1, 1};
  int bx[3], by[3], dx[3], dy[3], col[3];
  int mprev;

  typedef struct packed {
    logic            hs, vs, vis;
    logic [2:0][2:0] r, g, b;
  } exp_t;

  exp_t  q[$];
  string tq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      bx[i] = 0; by[i] = 0; dx[i] = 1; dy[i] = 1; col[i] = 7;
    end
    mprev = 0;
  endtask

  task automatic axis(inout int p, inout int d, input int spd, input int mx, inout bit hit);
    if (d == 1) begin
      if (p + spd >= mx) begin p = mx; d = 0; hit = 1'b1; end
      else p = p + spd;
    end else begin
      if (p <= spd) begin p = 0; d = 1; hit = 1'b1; end
      else p = p - spd;
    end
  endtask

  // Records what the outputs must show two cycles after the current inputs,
  // then applies the frame tick (if any) to the model.
  task automatic model_push(input string tag);
    exp_t e;
    bit   hit;
    e = '0;
    e.hs = hs; e.vs = vs; e.vis = vis;
    for (int i = 0; i < 3; i++) begin
      if (vis && int'(hp) >= bx[i] && int'(hp) < bx[i] + BS[i]
               && int'(vp) >= by[i] && int'(vp) < by[i] + BS[i]) begin
        e.r[i] = 3'(((col[i] / 4) % 2) * 7);
        e.g[i] = 3'(((col[i] / 2) % 2) * 7);
        e.b[i] = 3'((col[i] % 2) * 7);
      end
    end
    q.push_back(e);
    tq.push_back(tag);
    if (vb && mprev == 0) begin
      for (int i = 0; i < 3; i++) begin
        hit = 1'b0;
        axis(bx[i], dx[i], HS[i], HV[i] - BS[i], hit);
        axis(by[i], dy[i], VS[i], VV[i] - BS[i], hit);
        if (hit) col[i] = (col[i] == 7) ? 1 : col[i] + 1;
      end
    end
    mprev = vb ? 1 : 0;
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL queue: observed empty expected entry");
      return;
    end
    e = q.pop_front();
    t = tq.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/u%0d/hsync", t, i), 32'(o_hs[i]), 32'(e.hs));
      chk($sformatf("%s/u%0d/vsync", t, i), 32'(o_vs[i]), 32'(e.vs));
      chk($sformatf("%s/u%0d/visible", t, i), 32'(o_vis[i]), 32'(e.vis));
      chk($sformatf("%s/u%0d/rgb", t, i), 32'({o_r[i], o_g[i], o_b[i]}),
          32'({e.r[i], e.g[i], e.b[i]}));
    end
  endtask

  task automatic step(input string tag, input logic s_hs, input logic s_vs, input logic s_vb,
                      input logic s_vis, input int s_hp, input int s_vp);
    @(negedge clk);
    check_out();
    hs = s_hs; vs = s_vs; vb = s_vb; vis = s_vis;
    hb = ~s_vis & ~s_vb;
    hp = 10'(s_hp); vp = 10'(s_vp);
    model_push(tag);
  endtask

  task automatic zero_chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/u%0d/sync", tag, i), 32'({o_hs[i], o_vs[i], o_vis[i]}), 32'(0));
      chk($sformatf("%s/u%0d/rgb", tag, i), 32'({o_r[i], o_g[i], o_b[i]}), 32'(0));
    end
  endtask

  task automatic release_rst(input string tag);
    exp_t z;
    z = '0;
    hs = 0; vs = 0; vb = 0; vis = 0; hb = 0; hp = '0; vp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); tq.delete();
    model_reset();
    q.push_back(z); tq.push_back(tag);
    model_push(tag);
    chk({tag, "/box_x"}, 32'(dut_m.box_x), 32'(0));
    chk({tag, "/box_y"}, 32'(dut_m.box_y), 32'(0));
    chk({tag, "/col"}, 32'(dut_m.col), 32'(7));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 zero_chk({tag, "_async"});
    repeat (3) @(negedge clk);
    release_rst(tag);
  endtask

  task automatic tick(input string tag);
    step(tag, 0, 1, 1, 0, 0, 0);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  int mx_t[6] = '{3, 6, 8, 5, 2, 0};
  int my_t[6] = '{1, 2, 3, 4, 3, 2};
  int mc_t[6] = '{7, 7, 1, 2, 2, 3};
  int cp_t[6] = '{1, 2, 3, 4, 3, 2};
  int cc_t[6] = '{7, 7, 7, 1, 1, 1};

  initial begin
    int vb_left;
    logic r_vb;
    rst_n = 1'b0;
    hs = 0; vs = 0; hb = 0; vb = 0; vis = 0; hp = '0; vp = '0;
    #3 zero_chk("por");
    release_rst("por_rel");

    // Two-cycle latency: single hsync pulse together with a box pixel.
    step("lat_pix", 1, 0, 0, 1, 0, 0);
    repeat (3) step("lat_idle", 0, 0, 0, 0, 0, 0);

    // Motion and corner tables, with an edge scan while the small box sits at (3,1).
    for (int t = 0; t < 6; t++) begin
      tick($sformatf("tick%0d", t + 1));
      chk($sformatf("motion_x_t%0d", t + 1), 32'(dut_m.box_x), 32'(mx_t[t]));
      chk($sformatf("motion_y_t%0d", t + 1), 32'(dut_m.box_y), 32'(my_t[t]));
      chk($sformatf("motion_col_t%0d", t + 1), 32'(dut_m.col), 32'(mc_t[t]));
      chk($sformatf("corner_x_t%0d", t + 1), 32'(dut_c.box_x), 32'(cp_t[t]));
      chk($sformatf("corner_y_t%0d", t + 1), 32'(dut_c.box_y), 32'(cp_t[t]));
      chk($sformatf("corner_col_t%0d", t + 1), 32'(dut_c.col), 32'(cc_t[t]));
      if (t == 0) begin
        for (int v = 0; v < 4; v++)
          for (int h = 2; h < 6; h++)
            step($sformatf("edge_h%0d_v%0d", h, v), 0, 0, 0, 1, h, v);
        step("edge_invisible", 0, 0, 0, 0, 3, 1);
        repeat (2) step("edge_flush", 0, 0, 0, 0, 0, 0);
      end
    end

    // Long vblank: one update only.
    repeat (50) step("long_vb", 0, 1, 1, 0, 0, 0);
    step("long_vb_end", 0, 0, 0, 0, 0, 0);
    chk("long_vb_x", 32'(dut_m.box_x), 32'(3));
    chk("long_vb_y", 32'(dut_m.box_y), 32'(1));
    chk("long_vb_col", 32'(dut_m.col), 32'(3));
    chk("long_vb_cx", 32'(dut_c.box_x), 32'(1));

    // Randomized traffic with a reset dropped in mid-frame.
    vb_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset("mid_rst");
      if (vb_left > 0) begin
        vb_left--; r_vb = 1'b1;
      end else begin
        r_vb = 1'b0;
        if ($urandom_range(0, 9) == 0) vb_left = $urandom_range(1, 6);
      end
      if (i % 4 == 3)
        step("rand", 1'($urandom), 1'($urandom), r_vb, 1'($urandom),
             $urandom_range(0, 1023), $urandom_range(0, 1023));
      else
        step("rand", 1'($urandom), 1'($urandom), r_vb, 1'($urandom),
             $urandom_range(0, 24), $urandom_range(0, 24));
    end
    repeat (2) step("drain", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
